// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: synchronized SPI inputs and register-bank outputs of spi_reg_ctrl.
// err_count exists only when SPI_ERR_COUNT_EN is defined.
interface spi_reg_ctrl_if #(
    parameter int NUM_REGS = 5
);
    logic                  ncs_s;
    logic                  copi_s;
    logic                  sclk_s;
    logic [8*NUM_REGS-1:0] regs_out;
    logic                  busy;
    logic                  txn_done;
    logic                  txn_err;
`ifdef SPI_ERR_COUNT_EN
    logic [7:0]            err_count;

    modport master (output ncs_s, copi_s, sclk_s,
                    input  regs_out, busy, txn_done, txn_err, err_count);
    modport slave  (input  ncs_s, copi_s, sclk_s,
                    output regs_out, busy, txn_done, txn_err, err_count);
`else
    modport master (output ncs_s, copi_s, sclk_s,
                    input  regs_out, busy, txn_done, txn_err);
    modport slave  (input  ncs_s, copi_s, sclk_s,
                    output regs_out, busy, txn_done, txn_err);
`endif
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: mode-0 write-only SPI peripheral decoding 16-bit frames into an 8-bit register bank.
// Optional SPI_ERR_COUNT_EN adds a saturating count of discarded frames.
module spi_reg_ctrl #(
    parameter int         NUM_REGS = 5,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_reg_ctrl_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                     r_state;
    logic [15:0]                r_shift;
    logic [4:0]                 r_bit_cnt;
    logic                       r_ovf;
    logic                       r_sclk_q;
    logic                       r_ncs_q;
    logic [NUM_REGS-1:0][7:0]   r_regs;
    logic                       r_done;
    logic                       r_err;

    logic       w_sclk_rise;
    logic       w_ncs_fall;
    logic       w_ncs_rise;
    logic [6:0] w_addr;
    logic       w_full;
    logic       w_valid;
    logic       w_read;

    assign w_sclk_rise = bus.sclk_s & ~r_sclk_q;
    assign w_ncs_fall  = ~bus.ncs_s & r_ncs_q;
    assign w_ncs_rise  = bus.ncs_s & ~r_ncs_q;
    assign w_addr      = r_shift[14:8];
    assign w_full      = (r_bit_cnt == 5'd16) & ~r_ovf;
    assign w_valid     = w_full & r_shift[15] & ({1'b0, w_addr} < 8'(NUM_REGS));
    assign w_read      = w_full & ~r_shift[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ovf     <= 1'b0;
            r_sclk_q  <= 1'b0;
            r_ncs_q   <= 1'b0;
            r_regs    <= {NUM_REGS{RST_VAL}};
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sclk_q <= bus.sclk_s;
            r_ncs_q  <= bus.ncs_s;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            if (r_state == IDLE) begin
                if (w_ncs_fall) begin
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                    r_ovf     <= 1'b0;
                    r_state   <= SHIFT;
                end
            end else if (w_ncs_rise) begin
                // frame end wins over a coincident SCLK edge, which is dropped
                r_state <= IDLE;
                r_done  <= w_valid;
                r_err   <= ~w_valid & ~w_read;
                for (int i = 0; i < NUM_REGS; i++)
                    if (w_valid && w_addr == 7'(i)) r_regs[i] <= r_shift[7:0];
            end else if (w_sclk_rise) begin
                if (r_bit_cnt < 5'd16) begin
                    r_shift   <= {r_shift[14:0], bus.copi_s};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.regs_out = r_regs;
    assign bus.busy     = (r_state == SHIFT);
    assign bus.txn_done = r_done;
    assign bus.txn_err  = r_err;

`ifdef SPI_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_count <= '0;
        else if (r_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end

    assign bus.err_count = r_err_count;
`endif
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed frames against spi_reg_ctrl with hand-computed register and pulse expectations.
module tb_spi_reg_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #50 clk = ~clk;

    spi_reg_ctrl_if #(.NUM_REGS(5)) bus ();
    spi_reg_ctrl #(.NUM_REGS(5), .RST_VAL(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int d0, e0;
    logic [39:0] exp_regs = '0;

    always @(negedge clk) begin
        if (bus.txn_done) done_cnt++;
        if (bus.txn_err) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame;
        bus.ncs_s = 1'b0;
        wait_clk(3);
    endtask

    task automatic shift_bits(input logic [16:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            bus.copi_s = v[16-k];
            wait_clk(2);
            bus.sclk_s = 1'b1;
            wait_clk(2);
            bus.sclk_s = 1'b0;
        end
        wait_clk(2);
    endtask

    task automatic end_frame;
        bus.ncs_s = 1'b1;
        wait_clk(1);
    endtask

    task automatic test_reset;
        bus.ncs_s = 1'b0; bus.copi_s = 1'b0; bus.sclk_s = 1'b0; rst_n = 1'b0;
        wait_clk(3);
        checks++;
        if (bus.regs_out !== 40'h0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_state: regs=%h busy=%b expected regs=%h busy=0", bus.regs_out, bus.busy, 40'h0);
        end
        checks++;
        if (bus.txn_done !== 1'b0 || bus.txn_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: done=%b err=%b expected 0 0", bus.txn_done, bus.txn_err);
        end
        rst_n = 1'b1;
        wait_clk(2);
        bus.ncs_s = 1'b1;
        wait_clk(4);
        checks++;
        if (bus.busy !== 1'b0 || done_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL post_reset_rise: busy=%b done=%0d err=%0d expected 0 0 0", bus.busy, done_cnt, err_cnt);
        end
`ifdef SPI_ERR_COUNT_EN
        checks++;
        if (bus.err_count !== 8'd0) begin
            errors++; $display("FAIL reset_err_count: got %0d expected 0", bus.err_count);
        end
`endif
    endtask

    task automatic test_valid_write;
        d0 = done_cnt; e0 = err_cnt;
        start_frame;
        shift_bits({16'h8155, 1'b0}, 16);
        checks++;
        if (bus.busy !== 1'b1 || bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL write_pre_commit: busy=%b regs=%h expected busy=1 regs=%h", bus.busy, bus.regs_out, exp_regs);
        end
        end_frame;
        exp_regs[15:8] = 8'h55;
        checks++;
        if (bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL write_commit: regs=%h expected %h", bus.regs_out, exp_regs);
        end
        checks++;
        if (bus.txn_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL write_done_pulse: done=%b busy=%b expected 1 0", bus.txn_done, bus.busy);
        end
        wait_clk(1);
        checks++;
        if (bus.txn_done !== 1'b0) begin
            errors++; $display("FAIL write_done_width: done=%b expected 0", bus.txn_done);
        end
        wait_clk(2);
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL write_pulse_count: done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_short_frame;
        d0 = done_cnt; e0 = err_cnt;
        start_frame;
        shift_bits({16'h8233, 1'b0}, 15);
        end_frame;
        checks++;
        if (bus.txn_err !== 1'b1 || bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL short_frame: err=%b regs=%h expected err=1 regs=%h", bus.txn_err, bus.regs_out, exp_regs);
        end
        wait_clk(3);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
            errors++; $display("FAIL short_pulse_count: done=%0d err=%0d expected 0 1", done_cnt - d0, err_cnt - e0);
        end
`ifdef SPI_ERR_COUNT_EN
        checks++;
        if (bus.err_count !== 8'd1) begin
            errors++; $display("FAIL short_err_count: got %0d expected 1", bus.err_count);
        end
`endif
    endtask

    task automatic test_bad_addr_ovf;
        d0 = done_cnt; e0 = err_cnt;
        start_frame;
        shift_bits({16'h87AA, 1'b0}, 16);
        end_frame;
        checks++;
        if (bus.txn_err !== 1'b1 || bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL bad_addr: err=%b regs=%h expected err=1 regs=%h", bus.txn_err, bus.regs_out, exp_regs);
        end
        wait_clk(3);
        start_frame;
        shift_bits({16'h80F0, 1'b1}, 17);
        end_frame;
        checks++;
        if (bus.txn_err !== 1'b1 || bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL overflow: err=%b regs=%h expected err=1 regs=%h", bus.txn_err, bus.regs_out, exp_regs);
        end
        wait_clk(3);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 2) begin
            errors++; $display("FAIL bad_ovf_pulse_count: done=%0d err=%0d expected 0 2", done_cnt - d0, err_cnt - e0);
        end
`ifdef SPI_ERR_COUNT_EN
        checks++;
        if (bus.err_count !== 8'd3) begin
            errors++; $display("FAIL bad_ovf_err_count: got %0d expected 3", bus.err_count);
        end
`endif
    endtask

    task automatic test_back_to_back;
        d0 = done_cnt; e0 = err_cnt;
        start_frame;
        shift_bits({16'h0299, 1'b0}, 16);
        end_frame;
        wait_clk(3);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL read_noop: done=%0d err=%0d regs=%h expected 0 0 %h", done_cnt - d0, err_cnt - e0, bus.regs_out, exp_regs);
        end
        start_frame;
        shift_bits({16'h8401, 1'b0}, 16);
        end_frame;
        exp_regs[39:32] = 8'h01;
        checks++;
        if (bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL b2b_first: regs=%h expected %h", bus.regs_out, exp_regs);
        end
        start_frame;
        shift_bits({16'h84FE, 1'b0}, 16);
        end_frame;
        exp_regs[39:32] = 8'hFE;
        checks++;
        if (bus.regs_out !== exp_regs) begin
            errors++; $display("FAIL b2b_second: regs=%h expected %h", bus.regs_out, exp_regs);
        end
        wait_clk(3);
        checks++;
        if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL b2b_pulse_count: done=%0d err=%0d expected 2 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid;
        start_frame;
        shift_bits({16'h8377, 1'b0}, 8);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: busy=%b expected 1", bus.busy);
        end
        rst_n = 1'b0;
        bus.ncs_s = 1'b0;
        wait_clk(2);
        exp_regs = '0;
        rst_n = 1'b1;
        wait_clk(2);
        d0 = done_cnt; e0 = err_cnt;
        bus.ncs_s = 1'b1;
        wait_clk(3);
        checks++;
        if (bus.busy !== 1'b0 || bus.regs_out !== exp_regs || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL mid_reset: busy=%b regs=%h done=%0d err=%0d expected 0 %h 0 0", bus.busy, bus.regs_out, done_cnt - d0, err_cnt - e0, exp_regs);
        end
        start_frame;
        shift_bits({16'h8377, 1'b0}, 16);
        end_frame;
        exp_regs[31:24] = 8'h77;
        checks++;
        if (bus.regs_out !== exp_regs || bus.txn_done !== 1'b1) begin
            errors++; $display("FAIL after_reset_write: regs=%h done=%b expected %h 1", bus.regs_out, bus.txn_done, exp_regs);
        end
    endtask

    initial begin
        test_reset;
        test_valid_write;
        test_short_frame;
        test_bad_addr_ovf;
        test_back_to_back;
        test_reset_mid;
        wait_clk(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
SPI peripheral controller that consumes the already-synchronized nCS/COPI/SCLK triplet and decodes 16-bit write transactions into a small 8-bit register bank. It sits directly after the 2-stage input synchronizers and drives the configuration registers, such as output enables and PWM settings, for the rest of the design. SPI mode 0, MSB first, write-only peripheral.

Parameters:
NUM_REGS, 5, number of 8-bit registers in the bank (1..128)
RST_VAL, 8'h00, reset value loaded into every register

Ports:
clk  input  1  system clock (10 MHz), all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ncs_s  input  1  synchronized chip select, active low
copi_s  input  1  synchronized controller-out/peripheral-in data
sclk_s  input  1  synchronized SPI clock
regs_out  output  8*NUM_REGS  register bank, reg i at [8*i+7:8*i]
busy  output  1  high while a transaction is in progress (state SHIFT)
txn_done  output  1  one-cycle pulse: a valid write was committed
txn_err  output  1  one-cycle pulse: a malformed transaction was discarded

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift_reg=0, bit_cnt=0, ovf=0, sclk_q=0, ncs_q=0, every register=RST_VAL, busy=0, txn_done=0, txn_err=0.
- Edge detect, registered history: sclk_rise = sclk_s & ~sclk_q; ncs_fall = ~ncs_s & ncs_q; ncs_rise = ncs_s & ~ncs_q. ncs_q resets to 0 so the post-reset 0->1 of the synchronizer output is a rise seen in IDLE, which is ignored.
- Frame format, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- FSM states: IDLE, SHIFT.
  - IDLE: on ncs_fall, clear shift_reg, bit_cnt and ovf, then go to SHIFT. sclk_rise and ncs_rise are ignored in IDLE.
  - SHIFT, on sclk_rise with ncs_rise=0: if bit_cnt<16, shift_reg <= {shift_reg[14:0], copi_s} and bit_cnt++. Otherwise set ovf=1 (bit_cnt saturates at 16).
  - SHIFT, on ncs_rise: go to IDLE and evaluate the frame in the same cycle. ncs_rise has priority over a simultaneous sclk_rise; that SCLK edge is dropped.
- Frame evaluation on ncs_rise:
  - Valid write = bit_cnt==16 AND ovf==0 AND bit15==1 AND addr<NUM_REGS. The register at addr gets data on that clock edge. txn_done=1 on the next cycle for exactly 1 cycle.
  - Read frame = bit_cnt==16, ovf==0, bit15==0. This is a no-op: no pulse on either output, no register change.
  - Error = bit_cnt!=16, OR ovf==1, OR (write with addr>=NUM_REGS). No register change; txn_err=1 on the next cycle for 1 cycle.
- busy is high exactly while state==SHIFT.
- Latency: a committed value appears on regs_out 1 clk after the ncs_rise cycle. Allowing for the external synchronizers, this is about 3 clk after the raw nCS rises.
- Reset mid-transaction: the partial frame is lost, the bank returns to RST_VAL, and the block re-arms only on the next ncs_fall.
- An ncs_fall while already in SHIFT cannot occur without an intervening rise and needs no special handling.
- Only one register is written per frame; all other registers hold their value.

Optional Feature:
Macro SPI_ERR_COUNT_EN.
- Defined: adds output err_count (8 bits, reset 0). It increments on each txn_err pulse and saturates at 8'hFF, with no wrap.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n=0, release -> regs_out all RST_VAL (0x00), busy=0, no txn_done/txn_err pulse, including after the synchronizer's post-reset rise of ncs_s.
- Valid write: frame 0x8155 (write, addr 1, data 0x55) -> regs_out[15:8]=0x55 one clk after ncs_rise, txn_done single pulse, other registers unchanged.
- Short frame: 15 SCLK edges with bits of 0x8233, then nCS high -> no register change, txn_err pulse; err_count=1 when SPI_ERR_COUNT_EN.
- Bad address and overflow: frame 0x87AA (addr 7 >= NUM_REGS=5) -> txn_err, no write. 17-edge frame starting 0x80F0 -> txn_err, reg0 unchanged.
- Read and back-to-back: frame 0x0299 -> no pulse, no change. Then immediately 0x8401 followed by 0x84FE -> reg4 ends at 0xFE with two txn_done pulses.
- Reset mid-frame: assert rst_n after 8 edges of 0x8377 -> reg3=0x00, busy=0. A subsequent full frame 0x8377 -> reg3=0x77.
